// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer between the single-cycle RV32I datapath and a
// variable-latency data-memory bus.
//
// A decoded load/store is checked for legality in IDLE. A legal access is
// latched (size/sign, address, lane-placed write data, byte mask) and the
// sequencer moves to REQ. It holds the bus request in REQ until i_bus_ack,
// then spends one cycle in DONE, where the PC is released and load data is
// presented. An illegal access raises lsu_exc for that cycle and never
// reaches the bus.
//
// Bus handshake: o_bus_req is high for every REQ cycle. Address, we, wdata
// and bmask are held stable for that whole time. The bus answers with a
// single-cycle i_bus_ack, and i_bus_rdata must be valid in the same cycle.
// An i_bus_ack outside REQ is ignored.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a REQ that waits
// TIMEOUT_CYC cycles without an ack. An aborted access still ends in DONE,
// pulses lsu_exc there, and forces ld_data to 0 with ld_vld low.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_lsu_req, i_lsu_we      load/store request, 1 = store
//   i_fun3, i_addr, i_wdata  access size/sign, byte address, rs2 data
//   stall                    hold PC / suppress rd write
//   ld_data, ld_vld          extended load result (registered), valid in DONE
//   lsu_exc                  misaligned / illegal fun3 / timeout pulse
//   o_bus_*                  bus request, we, word address, wdata, byte mask
//   i_bus_ack, i_bus_rdata   bus completion and read word
//   dbg_state                current FSM state (0 IDLE, 1 REQ, 2 DONE)
module lsu_seq #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_fun3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_vld,
  output logic        lsu_exc,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_bmask,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  fun3_q, fun3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        tmo_q, tmo_d;   // current DONE was reached by timeout
  logic        expire;         // REQ has used up its cycle budget

  // Request decode: legality, lane placement
  logic        fun3_ok, align_ok, acc_legal;
  logic [3:0]  req_bmask;
  logic [31:0] req_wdata;

  always_comb begin
    if (i_lsu_we) fun3_ok = (i_fun3 == 3'b000) || (i_fun3 == 3'b001) || (i_fun3 == 3'b010);
    else          fun3_ok = (i_fun3 == 3'b000) || (i_fun3 == 3'b001) || (i_fun3 == 3'b010) ||
                            (i_fun3 == 3'b100) || (i_fun3 == 3'b101);
    case (i_fun3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~i_addr[0];
      2'b10:   align_ok = (i_addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    acc_legal = fun3_ok && align_ok;
  end

  always_comb begin
    case (i_fun3[1:0])
      2'b00: begin
        req_bmask = 4'b0001 << i_addr[1:0];
        req_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        req_bmask = 4'b0011 << {i_addr[1], 1'b0};
        req_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        req_bmask = 4'hF;
        req_wdata = i_wdata;
      end
    endcase
  end

  // Load extraction from the returned word, using the latched access
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rd_byte = i_bus_rdata[7:0];
      2'b01:   rd_byte = i_bus_rdata[15:8];
      2'b10:   rd_byte = i_bus_rdata[23:16];
      default: rd_byte = i_bus_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (fun3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = i_bus_rdata;
    endcase
  end

  // Optional REQ timeout
`ifdef LSU_TIMEOUT_EN
  localparam int CNT_NEED = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W    = (CNT_NEED > 8) ? CNT_NEED : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts REQ cycles already spent, so the budget is reached in the
  // cycle where this one makes TIMEOUT_CYC.
  assign expire = (state_q == S_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_REQ) cnt_d = cnt_q + 1'b1;
    else                  cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
  // TIMEOUT_CYC only matters when the timeout is built in.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
`endif

  // FSM next state and datapath
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    fun3_d    = fun3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bmask_d   = bmask_q;
    ld_data_d = ld_data_q;
    tmo_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_lsu_req && acc_legal) begin
          state_d = S_REQ;
          we_d    = i_lsu_we;
          fun3_d  = i_fun3;
          addr_d  = i_addr;
          wdata_d = req_wdata;
          bmask_d = req_bmask;
        end
      end
      S_REQ: begin
        if (i_bus_ack) begin
          state_d = S_DONE;
          if (!we_q) ld_data_d = rd_ext;
        end else if (expire) begin
          state_d   = S_DONE;
          tmo_d     = 1'b1;
          ld_data_d = '0;
        end
      end
      // The request seen in DONE is still the finishing instruction.
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      fun3_q    <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      bmask_q   <= 4'd0;
      ld_data_q <= 32'd0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      fun3_q    <= fun3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bmask_q   <= bmask_d;
      ld_data_q <= ld_data_d;
      tmo_q     <= tmo_d;
    end
  end

  // Outputs. The combinational IDLE terms are gated by reset so that stall
  // and lsu_exc read 0 while reset is held.
  logic idle_req;
  assign idle_req = i_rst_n && (state_q == S_IDLE) && i_lsu_req;

  assign stall       = (idle_req && acc_legal) || (state_q == S_REQ);
  assign lsu_exc     = (idle_req && !acc_legal) || ((state_q == S_DONE) && tmo_q);
  assign ld_vld      = (state_q == S_DONE) && !we_q && !tmo_q;
  assign ld_data     = ld_data_q;
  assign o_bus_req   = (state_q == S_REQ);
  assign o_bus_we    = we_q;
  assign o_bus_addr  = {addr_q[31:2], 2'b00};
  assign o_bus_wdata = wdata_q;
  assign o_bus_bmask = bmask_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lsu_seq.sv
module tb_lsu_seq;

  localparam int TMO = 255;

  logic        clk;
  logic        rst_n;
  logic        i_lsu_req, i_lsu_we;
  logic [2:0]  i_fun3;
  logic [31:0] i_addr, i_wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_vld, lsu_exc;
  logic        o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_bmask;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic [1:0]  dbg_state;

  lsu_seq #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_fun3(i_fun3),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .stall(stall), .ld_data(ld_data), .ld_vld(ld_vld), .lsu_exc(lsu_exc),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_bmask(o_bus_bmask),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_ld_q[$];
  logic [68:0] exp_bus_q[$];   // {we, word addr, bmask, wdata}

  task automatic check(input string name, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: checks every load result and every new bus request
  logic bus_req_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_req_prev = 1'b0;
    end else begin
      if (ld_vld) begin
        if (exp_ld_q.size() == 0) check("ld_vld_unexpected", {37'd0, ld_data}, 69'h1_0000_0000);
        else check("ld_data", {37'd0, ld_data}, {37'd0, exp_ld_q.pop_front()});
      end
      if (o_bus_req && !bus_req_prev) begin
        if (exp_bus_q.size() == 0) check("bus_req_unexpected", {68'd0, o_bus_req}, 69'd0);
        else check("bus_fields", {o_bus_we, o_bus_addr, o_bus_bmask, o_bus_wdata},
                   exp_bus_q.pop_front());
      end
      bus_req_prev = o_bus_req;
    end
  end

  // Driver tasks (start and end 1 time unit after a rising edge)
  // k = ack cycle after acceptance (0 = never ack)
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int k,
                        input int exp_stall, input logic [3:0] e_mask,
                        input logic [31:0] e_bwd, input logic [31:0] e_ld,
                        output logic exc_done);
    int  stall_cyc = 0;
    bit  done = 0;
    exp_bus_q.push_back({we, a[31:2], 2'b00, e_mask, e_bwd});
    if (!we && k > 0) exp_ld_q.push_back(e_ld);
    i_lsu_req = 1'b1; i_lsu_we = we; i_fun3 = f3; i_addr = a; i_wdata = wd; i_bus_rdata = rd;
    exc_done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      i_bus_ack = (k > 0) && (c == k);
      @(negedge clk);
      if (stall) stall_cyc++;
      else begin
        done = 1;
        exc_done = lsu_exc;
      end
      @(posedge clk); #1;
    end
    i_bus_ack = 1'b0; i_lsu_req = 1'b0;
    if (!done) check("access_timeout", 69'd0, 69'd1);
    check("stall_cycles", 69'(stall_cyc), 69'(exp_stall));
  endtask

  task automatic illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    i_lsu_req = 1'b1; i_lsu_we = we; i_fun3 = f3; i_addr = a; i_wdata = 32'h5555_5555;
    @(negedge clk);
    check("exc_pulse", {68'd0, lsu_exc}, 69'd1);
    check("exc_stall", {68'd0, stall}, 69'd0);
    @(posedge clk); #1;
    i_lsu_req = 1'b0;
    @(negedge clk);
    check("exc_stay_idle", {67'd0, dbg_state}, 69'd0);
    @(posedge clk); #1;
  endtask

  // Stimulus
  logic exc_d;
  initial begin
    rst_n = 1'b0;
    i_lsu_req = 0; i_lsu_we = 0; i_fun3 = 0; i_addr = 0; i_wdata = 0;
    i_bus_ack = 0; i_bus_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_stall",   {68'd0, stall},       69'd0);
    check("rst_ld_data", {37'd0, ld_data},     69'd0);
    check("rst_ld_vld",  {68'd0, ld_vld},      69'd0);
    check("rst_exc",     {68'd0, lsu_exc},     69'd0);
    check("rst_bus_req", {68'd0, o_bus_req},   69'd0);
    check("rst_bus_we",  {68'd0, o_bus_we},    69'd0);
    check("rst_addr",    {37'd0, o_bus_addr},  69'd0);
    check("rst_wdata",   {37'd0, o_bus_wdata}, 69'd0);
    check("rst_bmask",   {65'd0, o_bus_bmask}, 69'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // we  f3     addr          wdata         rdata         k  stall mask     bus wdata     load
    access(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 3, 4'hF, 32'h0,        32'hDEADBEEF, exc_d);
    check("exc_lw", {68'd0, exc_d}, 69'd0);
    access(0, 3'b000, 32'h103, 32'h0,        32'h80123456, 1, 2, 4'h8, 32'h0,        32'hFFFFFF80, exc_d);
    access(0, 3'b100, 32'h103, 32'h0,        32'h80123456, 1, 2, 4'h8, 32'h0,        32'h00000080, exc_d);
    access(1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        3, 4, 4'hC, 32'hABCDABCD, 32'h0,        exc_d);
    check("ld_data_held", {37'd0, ld_data}, {37'd0, 32'h00000080});
    access(0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1, 2, 4'hC, 32'h0,        32'hFFFF8001, exc_d);
    access(0, 3'b101, 32'h100, 32'h0,        32'h8001F234, 2, 3, 4'h3, 32'h0,        32'h0000F234, exc_d);
    access(0, 3'b000, 32'h101, 32'h0,        32'h11227F44, 1, 2, 4'h2, 32'h0,        32'h0000007F, exc_d);
    access(1, 3'b000, 32'h001, 32'h123456A5, 32'h0,        1, 2, 4'h2, 32'hA5A5A5A5, 32'h0,        exc_d);
    access(1, 3'b010, 32'h30C, 32'hCAFEF00D, 32'h0,        4, 5, 4'hF, 32'hCAFEF00D, 32'h0,        exc_d);

    // Illegal accesses never reach the bus
    illegal(0, 3'b010, 32'h101);   // misaligned LW
    illegal(0, 3'b001, 32'h203);   // misaligned LH
    illegal(0, 3'b011, 32'h100);   // bad load fun3
    illegal(1, 3'b100, 32'h100);   // bad store fun3

    // Stray ack in IDLE is ignored
    i_bus_ack = 1'b1; i_bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    i_bus_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_state", {67'd0, dbg_state}, 69'd0);
    check("stray_ack_ld",    {37'd0, ld_data},   {37'd0, 32'h0000007F});
    @(posedge clk); #1;

    // Reset while in REQ
    exp_bus_q.push_back({1'b0, 32'h400, 4'hF, 32'h0});
    i_lsu_req = 1'b1; i_lsu_we = 0; i_fun3 = 3'b010; i_addr = 32'h400; i_wdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0; i_lsu_req = 1'b0;
    #1;
    check("rst_mid_bus_req", {68'd0, o_bus_req},  69'd0);
    check("rst_mid_stall",   {68'd0, stall},      69'd0);
    check("rst_mid_addr",    {37'd0, o_bus_addr}, 69'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 3'b010, 32'h404, 32'h0, 32'h01234567, 1, 2, 4'hF, 32'h0, 32'h01234567, exc_d);

`ifdef LSU_TIMEOUT_EN
    access(0, 3'b010, 32'h500, 32'h0, 32'h0, 0, TMO + 1, 4'hF, 32'h0, 32'h0, exc_d);
    check("tmo_exc",     {68'd0, exc_d},   69'd1);
    check("tmo_ld_data", {37'd0, ld_data}, 69'd0);
`endif

    repeat (3) @(posedge clk);
    check("ld_queue_empty",  69'(exp_ld_q.size()),  69'd0);
    check("bus_queue_empty", 69'(exp_bus_q.size()), 69'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
